d_cache_wb_2way: RTL and testbench
==================================

# d_cache_wb_2way

Two-way set-associative, write-back, write-allocate data cache with multi-word lines and per-set LRU replacement. It sits between the MIPS core data port and the AXI bridge's sram-like data port. The core side uses the same req/addr_ok/data_ok handshake as the existing one-word direct-mapped data cache. Misses evict a dirty victim line word-by-word and then refill the whole line word-by-word.

## Interface
- INDEX_WIDTH, 6, set index bits (sets = 2^INDEX_WIDTH)
- OFFSET_WIDTH, 4, byte offset bits; words per line WPL = 2^(OFFSET_WIDTH-2), must be >= 2
- TAG_WIDTH (localparam), 32-INDEX_WIDTH-OFFSET_WIDTH
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_data_req  in  1  core request, held stable with addr/wr/size/wdata until addr_ok
- cpu_data_wr  in  1  1 = store
- cpu_data_size  in  2  00 byte, 01 half, 10 word
- cpu_data_addr  in  32  byte address
- cpu_data_wdata  in  32  store data, byte lanes already aligned
- cpu_data_rdata  out  32  load data
- cpu_data_addr_ok  out  1  request accepted
- cpu_data_data_ok  out  1  data returned / store done
- cache_data_req  out  1  memory request
- cache_data_wr  out  1  1 = write-back word
- cache_data_size  out  2  always 2'b10
- cache_data_addr  out  32  word-aligned memory address
- cache_data_wdata  out  32  victim word
- cache_data_rdata  in  32  refill word
- cache_data_addr_ok  in  1  memory accepted request
- cache_data_data_ok  in  1  memory completed transfer

## Operation
- Address split: tag [31:INDEX_WIDTH+OFFSET_WIDTH], index, word select [OFFSET_WIDTH-1:2].
- Per way per set: valid, dirty, tag, WPL data words. Per set: one lru bit naming the least-recently-used way.
- Hit = valid & tag match in either way. A tag match in both ways cannot occur; no tie handling.
- States: IDLE, WB (write back victim), RF (refill), with word counter cnt (OFFSET_WIDTH-2 bits) and a sent flag per word.
- IDLE, req & hit: addr_ok = data_ok = 1 combinationally. Load: rdata = hit way's selected word. Store: byte-masked merge into that word, dirty set. lru is set to the other way.
- IDLE, req & miss: the victim is way 0 if invalid, else way 1 if invalid, else the lru way. Victim way, index, request tag and victim tag are latched. Next state is WB if the victim is valid & dirty, else RF. cnt = 0. addr_ok/data_ok stay 0.
- WB: cache_data_req = 1, wr = 1 until addr_ok, for address {victim_tag, index, cnt, 2'b00} and wdata = victim word cnt. On data_ok: if cnt = WPL-1, go to RF with cnt = 0; else cnt++.
- RF: cache_data_req = 1, wr = 0 until addr_ok, for address {req_tag, index, cnt, 2'b00}. On data_ok, rdata is written into victim word cnt. On the last word: valid = 1, dirty = 0, tag written, lru = other way, state IDLE.
- After refill, the still-held core request hits in IDLE and completes as a normal hit, so stores need no separate miss path.
- rdata is 0 when not hitting in IDLE.
- Byte mask: size 00 selects lane addr[1:0]; size 01 selects lanes {addr[1],1},{addr[1],0}; size 10 selects all four lanes.

## Timing
- Reset values: state IDLE, cnt 0, sent 0, all valid/dirty/lru 0. Tag/data arrays are not reset. cache_data_req 0. cpu_data_addr_ok/data_ok 0. cache_data_wr 0.
- Hit latency 0 cycles: accepted and completed in the request cycle. Back-to-back hits run at one per cycle.
- Clean miss: WPL memory reads, then one hit cycle. Dirty miss: WPL writes, then WPL reads, then the hit cycle.
- Exactly one memory transaction is outstanding. After addr_ok, cache_data_req drops until that word's data_ok.
- data_ok arriving in the same cycle as addr_ok counts as completion of that word.
- rst asserted mid-WB/RF: the state machine returns to IDLE immediately and the partial line stays invalid. The bridge must itself be reset alongside.
- cpu_data_req dropping during a miss is illegal (core contract). Not checked.

## Structure
- Package d_cache_pkg holds the state encoding (IDLE, WB, RF), size encodings, and a byte-mask function (size, addr[1:0]) -> 4-bit mask, shared with the I-cache.
- Sub-module d_cache_way: one way's valid/dirty/tag/data arrays, with a read port (index, word) and a write port (word write with byte mask, line metadata write). It is instantiated twice. LRU bits and the FSM live in the top.

## Test plan
- Cold load from 0x0000_1004 -> 4 reads at 0x1000..0x100C. The word from 0x1004 is returned one cycle after the last data_ok. A repeat load hits in 0 cycles.
- Store byte 0xAB to 0x1005 (size 00) after the fill -> lane 1 is merged and the line becomes dirty. A load of 0x1004 returns old word with [15:8] = 0xAB.
- Three tags mapping to set 0 (0x0000_0000, 0x0000_1000, 0x0000_2000) with the first dirty -> the third access evicts way 0. Four writes go to 0x0000..0x000C with the stored data, then four reads of 0x2000..0x200C follow.
- LRU: fill ways with A, B, touch A, then miss C -> B is evicted with no write-back (clean). A still hits.
- Memory stalls: addr_ok delayed 3 cycles and data_ok coincident with addr_ok -> no duplicate or missing word and cnt advances exactly WPL times.
- rst pulsed during the RF word 2 -> cache_data_req is 0 next cycle, the line is invalid, and a re-request refetches all WPL words.

Source files
------------

// File: rtl/d_cache_pkg.sv
// Shared definitions for the data cache: controller states, access size
// encodings and the store byte-lane mask helper (also used by the I-cache).
package d_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RF   = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte lanes touched by an access of the given size at the given byte offset
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << addr_lo;
      SIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/d_cache_way.sv
// One way of the data cache: per-set valid/dirty/tag plus the line words.
// A single index/word pair serves both the combinational read port and the
// write port; a metadata write installs a freshly refilled clean line.
module d_cache_way
  import d_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [INDEX_WIDTH-1:0]                 index_i,
  input  logic [OFFSET_WIDTH-3:0]                word_i,
  output logic                                   valid_o,
  output logic                                   dirty_o,
  output logic [31-INDEX_WIDTH-OFFSET_WIDTH:0]   tag_o,
  output logic [31:0]                            rdata_o,
  input  logic                                   wr_en_i,
  input  logic [3:0]                             wr_mask_i,
  input  logic [31:0]                            wr_data_i,
  input  logic                                   wr_dirty_i,
  input  logic                                   meta_en_i,
  input  logic [31-INDEX_WIDTH-OFFSET_WIDTH:0]   meta_tag_i
);

  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << (INDEX_WIDTH + OFFSET_WIDTH - 2);

  logic [SETS-1:0]                          valid_q;
  logic [SETS-1:0]                          dirty_q;
  logic [31-INDEX_WIDTH-OFFSET_WIDTH:0]     tag_q  [SETS];
  logic [31:0]                              data_q [WORDS];
  logic [31:0]                              bit_mask;

  assign bit_mask = {{8{wr_mask_i[3]}}, {8{wr_mask_i[2]}}, {8{wr_mask_i[1]}}, {8{wr_mask_i[0]}}};

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign rdata_o = data_q[{index_i, word_i}];

  // Line status bits: stores mark the line dirty, a completed refill installs it clean
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_en_i && wr_dirty_i) begin
        dirty_q[index_i] <= 1'b1;
      end
      if (meta_en_i) begin
        valid_q[index_i] <= 1'b1;
        dirty_q[index_i] <= 1'b0;
      end
    end
  end

  // Tag and data storage are left uninitialised; valid gates their use
  always_ff @(posedge clk) begin
    if (meta_en_i) begin
      tag_q[index_i] <= meta_tag_i;
    end
    if (wr_en_i) begin
      data_q[{index_i, word_i}] <= (data_q[{index_i, word_i}] & ~bit_mask) | (wr_data_i & bit_mask);
    end
  end

endmodule

// File: rtl/d_cache_wb_2way.sv
// Two-way set-associative write-back, write-allocate data cache.
// Hits complete in the request cycle; a miss writes back a dirty victim
// word by word, refills the line word by word, then the held request hits.
module d_cache_wb_2way
  import d_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int CNT_WIDTH = OFFSET_WIDTH - 2;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    sent_q;
  logic                    victim_q;
  logic [INDEX_WIDTH-1:0]  idx_q;
  logic [TAG_WIDTH-1:0]    req_tag_q;
  logic [TAG_WIDTH-1:0]    vic_tag_q;
  logic [SETS-1:0]         lru_q;

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [CNT_WIDTH-1:0]    req_word;
  logic                    idle;
  logic [INDEX_WIDTH-1:0]  way_index;
  logic [CNT_WIDTH-1:0]    way_word;
  logic                    valid_w [2];
  logic                    dirty_w [2];
  logic [TAG_WIDTH-1:0]    tag_w   [2];
  logic [31:0]             word_w  [2];
  logic                    hit0, hit1, hit, hit_way;
  logic                    hit_go, miss_go;
  logic                    victim_sel;
  logic                    word_done, last_word;
  logic [3:0]              wr_mask;
  logic [31:0]             wr_data;

  assign req_tag  = cpu_data_addr[31 -: TAG_WIDTH];
  assign req_idx  = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word = cpu_data_addr[2 +: CNT_WIDTH];
  assign idle     = (state_q == ST_IDLE);

  // While idle the ways look at the core address; during a miss they look at the latched line
  assign way_index = idle ? req_idx  : idx_q;
  assign way_word  = idle ? req_word : cnt_q;

  assign hit0    = valid_w[0] && (tag_w[0] == req_tag);
  assign hit1    = valid_w[1] && (tag_w[1] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;
  assign hit_go  = idle && cpu_data_req && hit;
  assign miss_go = idle && cpu_data_req && !hit;

  assign victim_sel = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[req_idx]);

  // A word is finished on data_ok, including data_ok coincident with addr_ok
  assign word_done = !idle && (sent_q ? cache_data_data_ok : (cache_data_addr_ok && cache_data_data_ok));
  assign last_word = (cnt_q == CNT_LAST);

  assign wr_mask = idle ? byte_mask(cpu_data_size, cpu_data_addr[1:0]) : 4'hF;
  assign wr_data = idle ? cpu_data_wdata : cache_data_rdata;

  for (genvar g = 0; g < 2; g++) begin : g_way
    localparam logic WAY = 1'(g);
    logic store_en, fill_en;
    assign store_en = hit_go && cpu_data_wr && (hit_way == WAY);
    assign fill_en  = (state_q == ST_RF) && word_done && (victim_q == WAY);

    d_cache_way #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .index_i   (way_index),
      .word_i    (way_word),
      .valid_o   (valid_w[g]),
      .dirty_o   (dirty_w[g]),
      .tag_o     (tag_w[g]),
      .rdata_o   (word_w[g]),
      .wr_en_i   (store_en || fill_en),
      .wr_mask_i (wr_mask),
      .wr_data_i (wr_data),
      .wr_dirty_i(idle),
      .meta_en_i (fill_en && last_word),
      .meta_tag_i(req_tag_q)
    );
  end

  // Miss controller: latch the victim, stream out a dirty line, then stream in the new one
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sent_q    <= 1'b0;
      victim_q  <= 1'b0;
      idx_q     <= '0;
      req_tag_q <= '0;
      vic_tag_q <= '0;
      lru_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit_go) begin
            lru_q[req_idx] <= ~hit_way;
          end else if (miss_go) begin
            victim_q  <= victim_sel;
            idx_q     <= req_idx;
            req_tag_q <= req_tag;
            vic_tag_q <= tag_w[victim_sel];
            cnt_q     <= '0;
            sent_q    <= 1'b0;
            state_q   <= (valid_w[victim_sel] && dirty_w[victim_sel]) ? ST_WB : ST_RF;
          end
        end
        ST_WB, ST_RF: begin
          if (word_done) begin
            sent_q <= 1'b0;
            if (last_word) begin
              cnt_q <= '0;
              if (state_q == ST_WB) begin
                state_q <= ST_RF;
              end else begin
                state_q       <= ST_IDLE;
                lru_q[idx_q]  <= ~victim_q;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (cache_data_addr_ok && !sent_q) begin
            sent_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_data_addr_ok = hit_go;
  assign cpu_data_data_ok = hit_go;
  assign cpu_data_rdata   = hit_go ? word_w[hit_way] : 32'd0;

  assign cache_data_req   = !idle && !sent_q;
  assign cache_data_wr    = (state_q == ST_WB) && !sent_q;
  assign cache_data_size  = SIZE_WORD;
  assign cache_data_addr  = (state_q == ST_WB) ? {vic_tag_q, idx_q, cnt_q, 2'b00} :
                            (state_q == ST_RF) ? {req_tag_q, idx_q, cnt_q, 2'b00} : 32'd0;
  assign cache_data_wdata = (state_q == ST_WB) ? word_w[victim_q] : 32'd0;

endmodule

// File: tb/tb_d_cache_wb_2way.sv
// Bench for d_cache_wb_2way: an access-level cache model (sets of tagged
// lines, LRU bit, architectural memory image) predicts load data, memory
// traffic and latency; a responder stands in for the AXI bridge.
module tb_d_cache_wb_2way;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_data_req = 1'b0;
  logic        cpu_data_wr = 1'b0;
  logic [1:0]  cpu_data_size = 2'b10;
  logic [31:0] cpu_data_addr = 32'd0;
  logic [31:0] cpu_data_wdata = 32'd0;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata = 32'd0;
  logic        cache_data_addr_ok = 1'b0;
  logic        cache_data_data_ok = 1'b0;

  always #5 clk = ~clk;

  d_cache_wb_2way #(.INDEX_WIDTH(6), .OFFSET_WIDTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_data_req      (cpu_data_req),
    .cpu_data_wr       (cpu_data_wr),
    .cpu_data_size     (cpu_data_size),
    .cpu_data_addr     (cpu_data_addr),
    .cpu_data_wdata    (cpu_data_wdata),
    .cpu_data_rdata    (cpu_data_rdata),
    .cpu_data_addr_ok  (cpu_data_addr_ok),
    .cpu_data_data_ok  (cpu_data_data_ok),
    .cache_data_req    (cache_data_req),
    .cache_data_wr     (cache_data_wr),
    .cache_data_size   (cache_data_size),
    .cache_data_addr   (cache_data_addr),
    .cache_data_wdata  (cache_data_wdata),
    .cache_data_rdata  (cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok),
    .cache_data_data_ok(cache_data_data_ok)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        expQ[$];
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] golden [logic [31:0]];
  logic [31:0] expRdata = 32'd0;

  bit          mValid [64][2];
  bit          mDirty [64][2];
  logic [21:0] mTag   [64][2];
  bit          mLru   [64];

  int aDelay = 0;
  int dDelay = 0;
  bit coincide = 1'b0;
  int txnCount = 0;
  int writeCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] initPattern(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : initPattern(a);
  endfunction

  function automatic logic [31:0] goldRead(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : initPattern(a);
  endfunction

  // After reset the cache is empty, so the architectural view falls back to memory
  task automatic modelReset;
    for (int s = 0; s < 64; s++) begin
      mValid[s][0] = 1'b0; mValid[s][1] = 1'b0;
      mDirty[s][0] = 1'b0; mDirty[s][1] = 1'b0;
      mLru[s] = 1'b0;
    end
    golden.delete();
    foreach (mem[k]) golden[k] = mem[k];
    expQ.delete();
  endtask

  // Access-level model: decide hit/miss, queue the memory traffic, update architectural data
  task automatic modelAccess(input logic [31:0] addr, input bit wr, input logic [1:0] size,
                             input logic [31:0] wdata, output int words);
    int set;
    int way;
    int v;
    logic [21:0] tag;
    logic [31:0] wa;
    logic [31:0] a;
    logic [31:0] cur;
    set = int'(addr[9:4]);
    tag = addr[31:10];
    wa = {addr[31:2], 2'b00};
    way = -1;
    words = 0;
    for (int w = 0; w < 2; w++) begin
      if (mValid[set][w] && mTag[set][w] == tag) way = w;
    end
    if (way < 0) begin
      v = !mValid[set][0] ? 0 : (!mValid[set][1] ? 1 : int'(mLru[set]));
      if (mValid[set][v] && mDirty[set][v]) begin
        for (int i = 0; i < 4; i++) begin
          a = {mTag[set][v], addr[9:4], 4'(i * 4)};
          expQ.push_back('{wr: 1'b1, addr: a, wdata: goldRead(a)});
          words++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        a = {tag, addr[9:4], 4'(i * 4)};
        expQ.push_back('{wr: 1'b0, addr: a, wdata: 32'd0});
        words++;
      end
      mValid[set][v] = 1'b1;
      mDirty[set][v] = 1'b0;
      mTag[set][v] = tag;
      way = v;
    end
    mLru[set] = (way == 0);
    if (wr) begin
      cur = goldRead(wa);
      for (int lane = 0; lane < 4; lane++) begin
        if (size == 2'b10 || (size == 2'b01 && (lane / 2) == int'(addr[1])) ||
            (size == 2'b00 && lane == int'(addr[1:0])))
          cur[lane*8 +: 8] = wdata[lane*8 +: 8];
      end
      golden[wa] = cur;
      mDirty[set][way] = 1'b1;
    end
    expRdata = goldRead(wa);
  endtask

  // Bridge stand-in: addr_ok after aDelay waiting cycles, data_ok coincident or dDelay later
  int   waitCnt = 0;
  int   dCnt = 0;
  bit   busy = 1'b0;
  logic [31:0] pendRdata = 32'd0;
  txn_t cur;
  always @(negedge clk) begin
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata = 32'd0;
    if (rst) begin
      busy = 1'b0;
      waitCnt = 0;
    end else if (busy) begin
      if (dCnt < dDelay) dCnt++;
      else begin
        cache_data_data_ok = 1'b1;
        cache_data_rdata = pendRdata;
        busy = 1'b0;
      end
    end else if (cache_data_req) begin
      if (waitCnt < aDelay) waitCnt++;
      else begin
        waitCnt = 0;
        cache_data_addr_ok = 1'b1;
        txnCount++;
        if (expQ.size() == 0) begin
          checkOutput("txn_unexpected", cache_data_addr, 32'hFFFF_FFFF);
        end else begin
          cur = expQ.pop_front();
          checkOutput("txn_wr", 32'(cache_data_wr), 32'(cur.wr));
          checkOutput("txn_addr", cache_data_addr, cur.addr);
        end
        if (cache_data_wr) begin
          writeCount++;
          if (cur.wr) checkOutput("txn_wdata", cache_data_wdata, cur.wdata);
          mem[cache_data_addr] = cache_data_wdata;
          pendRdata = 32'd0;
        end else begin
          pendRdata = memRead(cache_data_addr);
        end
        if (coincide) begin
          cache_data_data_ok = 1'b1;
          cache_data_rdata = pendRdata;
        end else begin
          busy = 1'b1;
          dCnt = 0;
        end
      end
    end
  end

  // Every-cycle output check against the model
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (cpu_data_addr_ok !== cpu_data_data_ok)
        checkOutput("ok_pair", 32'(cpu_data_addr_ok), 32'(cpu_data_data_ok));
      if (cpu_data_data_ok && !cpu_data_wr)
        checkOutput("load_data", cpu_data_rdata, expRdata);
      else if (!cpu_data_data_ok)
        checkOutput("rdata_idle", cpu_data_rdata, 32'd0);
      if (cache_data_req)
        checkOutput("mem_size", 32'(cache_data_size), 32'd2);
    end
  end

  // Drive one core access at the current falling edge and hold it until data_ok
  task automatic applyStimulus(input logic [31:0] addr, input bit wr, input logic [1:0] size,
                               input logic [31:0] wdata, output int lat, output logic [31:0] rd);
    int words;
    int per;
    int expLat;
    bit done;
    modelAccess(addr, wr, size, wdata, words);
    per = coincide ? aDelay + 1 : aDelay + dDelay + 2;
    expLat = (words == 0) ? 1 : words * per + 2;
    cpu_data_req = 1'b1;
    cpu_data_wr = wr;
    cpu_data_size = size;
    cpu_data_addr = addr;
    cpu_data_wdata = wdata;
    lat = 0;
    rd = 32'd0;
    done = 1'b0;
    while (!done) begin
      #1;
      lat++;
      if (cpu_data_data_ok) begin
        done = 1'b1;
        rd = cpu_data_rdata;
      end else if (lat >= 400) begin
        checkOutput("access_timeout", 32'(lat), 32'(expLat));
        done = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
  endtask

  task automatic idleCycles(input int n);
    cpu_data_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset;
    #1;
    rst = 1'b1;
    cpu_data_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
    checkOutput("rst_data_ok", 32'(cpu_data_data_ok), 32'd0);
    checkOutput("rst_mem_req", 32'(cache_data_req), 32'd0);
    checkOutput("rst_mem_wr", 32'(cache_data_wr), 32'd0);
    checkOutput("rst_rdata", cpu_data_rdata, 32'd0);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int wc;
    int tc;
    int words;
    bit found;
    logic [31:0] rd;

    @(negedge clk);
    doReset();

    // Set 0: dirty way 0 is evicted by the third tag
    aDelay = 0; dDelay = 0; coincide = 1'b0;
    applyStimulus(32'h0000_0000, 1'b1, 2'b10, 32'h1111_2222, lat, rd);
    checkOutput("clean_miss_lat", 32'(lat), 32'd10);
    applyStimulus(32'h0000_1000, 1'b0, 2'b10, 32'd0, lat, rd);
    wc = writeCount;
    applyStimulus(32'h0000_2000, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("dirty_miss_lat", 32'(lat), 32'd18);
    checkOutput("dirty_miss_writes", 32'(writeCount - wc), 32'd4);
    checkOutput("wb_mem_word0", memRead(32'h0000_0000), 32'h1111_2222);
    checkOutput("third_tag_data", rd, 32'hC0DE_2000);
    idleCycles(1);

    // LRU in set 1: A, B, touch A, miss C evicts clean B
    applyStimulus(32'h0000_0010, 1'b0, 2'b10, 32'd0, lat, rd);
    applyStimulus(32'h0000_1010, 1'b0, 2'b10, 32'd0, lat, rd);
    applyStimulus(32'h0000_0010, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("touch_a_lat", 32'(lat), 32'd1);
    wc = writeCount;
    applyStimulus(32'h0000_2010, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("miss_c_lat", 32'(lat), 32'd10);
    checkOutput("miss_c_writes", 32'(writeCount - wc), 32'd0);
    applyStimulus(32'h0000_0010, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("a_still_hits", 32'(lat), 32'd1);
    idleCycles(2);

    // Cold load, repeat hit, byte and half stores, back-to-back hits
    doReset();
    applyStimulus(32'h0000_1004, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("cold_load_data", rd, 32'hC0DE_1004);
    checkOutput("cold_load_lat", 32'(lat), 32'd10);
    applyStimulus(32'h0000_1004, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("repeat_hit_lat", 32'(lat), 32'd1);
    applyStimulus(32'h0000_1005, 1'b1, 2'b00, 32'h0000_AB00, lat, rd);
    applyStimulus(32'h0000_1004, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("byte_merge", rd, 32'hC0DE_AB04);
    applyStimulus(32'h0000_100A, 1'b1, 2'b01, 32'hBEEF_0000, lat, rd);
    applyStimulus(32'h0000_1000, 1'b0, 2'b10, 32'd0, lat, rd);
    applyStimulus(32'h0000_1008, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("half_merge", rd, 32'hBEEF_1008);
    applyStimulus(32'h0000_100C, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("b2b_hit_lat", 32'(lat), 32'd1);
    idleCycles(1);

    // Stalled bridge: addr_ok after 3 waiting cycles, data_ok coincident
    aDelay = 3; dDelay = 0; coincide = 1'b1;
    applyStimulus(32'h0000_2000, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("stall_clean_lat", 32'(lat), 32'd18);
    tc = txnCount;
    applyStimulus(32'h0000_3000, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("stall_dirty_lat", 32'(lat), 32'd34);
    checkOutput("stall_txn_count", 32'(txnCount - tc), 32'd8);
    checkOutput("stall_wb_word2", memRead(32'h0000_1008), 32'hBEEF_1008);
    applyStimulus(32'h0000_1004, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("refetch_after_wb", rd, 32'hC0DE_AB04);
    idleCycles(1);

    // Reset during refill word 2, then the same line is fetched in full
    aDelay = 2; dDelay = 1; coincide = 1'b0;
    modelAccess(32'h0000_3040, 1'b0, 2'b10, 32'd0, words);
    cpu_data_req = 1'b1;
    cpu_data_wr = 1'b0;
    cpu_data_size = 2'b10;
    cpu_data_addr = 32'h0000_3040;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      #1;
      if (cache_data_req && !cache_data_wr && cache_data_addr == 32'h0000_3048) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("reach_rf_word2", 32'(found), 32'd1);
    rst = 1'b1;
    cpu_data_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("req_after_rst", 32'(cache_data_req), 32'd0);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    tc = txnCount;
    applyStimulus(32'h0000_3040, 1'b0, 2'b10, 32'd0, lat, rd);
    checkOutput("refetch_words", 32'(txnCount - tc), 32'd4);
    checkOutput("refetch_lat", 32'(lat), 32'd22);
    checkOutput("refetch_data", rd, 32'hC0DE_3040);
    idleCycles(2);

    checkOutput("txn_queue_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
